text_window_renderer: RTL and testbench

- Parametrised successor to the single-glyph character handler.
- Renders a COLS x ROWS grid of glyphs inside a window anchored at (posHorStart, posVerStart). Glyphs are GLYPH_W x GLYPH_H pixels, each pixel replicated SCALE x SCALE.
- Generates text-buffer/glyph-ROM read addresses from the pixel/line counters of the VGA timing generator.
- Takes back the glyph bit and flash attribute, and produces a registered RGB pixel with per-character flashing.

---
 rtl/text_window_renderer.sv | 217 +++++++++++++++++++++
 tb/tb_text_window_renderer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_window_renderer.sv
// Text window renderer: COLS x ROWS glyph grid with scaling, text/glyph addressing and per-character flash.
// Optional block cursor enabled by defining TEXT_CURSOR_EN.
module text_window_renderer #(
    parameter int PIX_W        = 10,
    parameter int LINE_W       = 9,
    parameter int COLS         = 16,
    parameter int ROWS         = 8,
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 16,
    parameter int SCALE        = 1,
    parameter int DEPTH        = 3,
    parameter int FLASH_FRAMES = 30,
    localparam int ADDR_W = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1,
    localparam int GR_W   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1,
    localparam int GC_W   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
    localparam int RGB_W  = 3 * DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PIX_W-1:0]  pixelCnt,
    input  logic [LINE_W-1:0] lineCnt,
    input  logic [PIX_W-1:0]  posHorStart,
    input  logic [LINE_W-1:0] posVerStart,
    input  logic              flashEn,
    input  logic [RGB_W-1:0]  charRGB,
    input  logic [RGB_W-1:0]  bgRGB,
    input  logic              bitDisp,
    input  logic              charFlash,
`ifdef TEXT_CURSOR_EN
    input  logic [ADDR_W-1:0] cursorAddr,
    input  logic              cursorEn,
`endif
    output logic              readEn,
    output logic [ADDR_W-1:0] charAddr,
    output logic [GR_W-1:0]   glyphRow,
    output logic [GC_W-1:0]   glyphCol,
    output logic              flashPhase,
    output logic [RGB_W-1:0]  vgaRGB
);

    localparam int SC_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int CR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CC_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FL_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCALE - 1);
    localparam logic [GR_W-1:0] GR_MAX = GR_W'(GLYPH_H - 1);
    localparam logic [GC_W-1:0] GC_MAX = GC_W'(GLYPH_W - 1);
    localparam logic [CR_W-1:0] CR_MAX = CR_W'(ROWS - 1);
    localparam logic [CC_W-1:0] CC_MAX = CC_W'(COLS - 1);
    localparam logic [FL_W-1:0] FL_MAX = FL_W'(FLASH_FRAMES - 1);

    logic [LINE_W-1:0] lineCntQ;
    logic              newLine, frameStart;

    logic              vActive, vActiveN, hActive, hActiveN;
    logic [SC_W-1:0]   rowScale, rowScaleN, colScale, colScaleN;
    logic [GR_W-1:0]   rowGlyph, rowGlyphN;
    logic [GC_W-1:0]   colGlyph, colGlyphN;
    logic [CR_W-1:0]   rowChar, rowCharN;
    logic [CC_W-1:0]   colChar, colCharN;
    logic              readEnN;
    logic [ADDR_W-1:0] addrN;

    logic              validQ;
    logic              showFg;
    logic [FL_W-1:0]   flashCnt;

    assign newLine    = (lineCnt != lineCntQ);
    assign frameStart = newLine && (lineCnt == '0);

    // Vertical cascade: scale -> glyph line -> text row, advanced once per line.
    always_comb begin
        vActiveN  = vActive;
        rowScaleN = rowScale;
        rowGlyphN = rowGlyph;
        rowCharN  = rowChar;
        if (newLine) begin
            if (lineCnt == '0) begin
                vActiveN = 1'b0;
            end else if (lineCnt == posVerStart) begin
                vActiveN  = 1'b1;
                rowScaleN = '0;
                rowGlyphN = '0;
                rowCharN  = '0;
            end else if (vActive) begin
                if (rowScale == SC_MAX) begin
                    rowScaleN = '0;
                    if (rowGlyph == GR_MAX) begin
                        rowGlyphN = '0;
                        if (rowChar == CR_MAX) begin
                            rowCharN = '0;
                            vActiveN = 1'b0;
                        end else begin
                            rowCharN = rowChar + CR_W'(1);
                        end
                    end else begin
                        rowGlyphN = rowGlyph + GR_W'(1);
                    end
                end else begin
                    rowScaleN = rowScale + SC_W'(1);
                end
            end
        end
    end

    // Horizontal cascade; a new line or pixel 0 always closes the window (no wrap).
    always_comb begin
        hActiveN  = hActive;
        colScaleN = colScale;
        colGlyphN = colGlyph;
        colCharN  = colChar;
        if (pixelCnt == '0 || newLine) begin
            hActiveN = 1'b0;
        end else if (pixelCnt == posHorStart && vActive) begin
            hActiveN  = 1'b1;
            colScaleN = '0;
            colGlyphN = '0;
            colCharN  = '0;
        end else if (hActive) begin
            if (colScale == SC_MAX) begin
                colScaleN = '0;
                if (colGlyph == GC_MAX) begin
                    colGlyphN = '0;
                    if (colChar == CC_MAX) begin
                        colCharN = '0;
                        hActiveN = 1'b0;
                    end else begin
                        colCharN = colChar + CC_W'(1);
                    end
                end else begin
                    colGlyphN = colGlyph + GC_W'(1);
                end
            end else begin
                colScaleN = colScale + SC_W'(1);
            end
        end
    end

    assign readEnN = hActiveN && vActiveN;
    assign addrN   = ADDR_W'(int'(rowCharN) * COLS + int'(colCharN));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lineCntQ <= '0;
            vActive  <= 1'b0;
            hActive  <= 1'b0;
            rowScale <= '0;
            rowGlyph <= '0;
            rowChar  <= '0;
            colScale <= '0;
            colGlyph <= '0;
            colChar  <= '0;
            readEn   <= 1'b0;
            charAddr <= '0;
            glyphRow <= '0;
            glyphCol <= '0;
        end else begin
            lineCntQ <= lineCnt;
            vActive  <= vActiveN;
            hActive  <= hActiveN;
            rowScale <= rowScaleN;
            rowGlyph <= rowGlyphN;
            rowChar  <= rowCharN;
            colScale <= colScaleN;
            colGlyph <= colGlyphN;
            colChar  <= colCharN;
            readEn   <= readEnN;
            // Addresses hold their last value outside the window.
            if (readEnN) begin
                charAddr <= addrN;
                glyphRow <= rowGlyphN;
                glyphCol <= colGlyphN;
            end
        end
    end

`ifdef TEXT_CURSOR_EN
    logic [ADDR_W-1:0] charAddrQ;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) charAddrQ <= '0;
        else        charAddrQ <= charAddr;
    end

    // Block cursor inverts the colour decision and overrides per-character flash.
    always_comb begin
        showFg = validQ && bitDisp && !(flashEn && charFlash && flashPhase);
        if (cursorEn && flashPhase && charAddrQ == cursorAddr) showFg = !showFg;
    end
`else
    always_comb begin
        showFg = validQ && bitDisp && !(flashEn && charFlash && flashPhase);
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            validQ     <= 1'b0;
            vgaRGB     <= '0;
            flashCnt   <= '0;
            flashPhase <= 1'b0;
        end else begin
            validQ <= readEn;
            vgaRGB <= showFg ? charRGB : bgRGB;
            if (frameStart) begin
                if (flashCnt == FL_MAX) begin
                    flashCnt   <= '0;
                    flashPhase <= ~flashPhase;
                end else begin
                    flashCnt <= flashCnt + FL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_text_window_renderer.sv
// Directed bench for text_window_renderer: compressed frames (short idle lines) drive two
// instances (SCALE=1 and SCALE=2); expectations come from a hand-computed vector table.
module tb_text_window_renderer;

    localparam int PIX_W = 10;
    localparam int LINE_W = 9;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [PIX_W-1:0]  pixelCnt, posHorStart;
    logic [LINE_W-1:0] lineCnt, posVerStart;
    logic              flashEn, bitDisp, charFlash;
    logic [8:0]        charRGB, bgRGB;

    logic       readEn, flashPhase, readEn2, flashPhase2;
    logic [6:0] charAddr, charAddr2;
    logic [3:0] glyphRow, glyphRow2;
    logic [2:0] glyphCol, glyphCol2;
    logic [8:0] vgaRGB, vgaRGB2;

    always #5 clock = ~clock;

    text_window_renderer #(.SCALE(1), .FLASH_FRAMES(2)) dut (
        .clock(clock), .reset(reset), .pixelCnt(pixelCnt), .lineCnt(lineCnt),
        .posHorStart(posHorStart), .posVerStart(posVerStart), .flashEn(flashEn),
        .charRGB(charRGB), .bgRGB(bgRGB), .bitDisp(bitDisp), .charFlash(charFlash),
`ifdef TEXT_CURSOR_EN
        .cursorAddr(7'd0), .cursorEn(1'b0),
`endif
        .readEn(readEn), .charAddr(charAddr), .glyphRow(glyphRow), .glyphCol(glyphCol),
        .flashPhase(flashPhase), .vgaRGB(vgaRGB));

    text_window_renderer #(.SCALE(2), .FLASH_FRAMES(2)) dut2 (
        .clock(clock), .reset(reset), .pixelCnt(pixelCnt), .lineCnt(lineCnt),
        .posHorStart(posHorStart), .posVerStart(posVerStart), .flashEn(flashEn),
        .charRGB(charRGB), .bgRGB(bgRGB), .bitDisp(bitDisp), .charFlash(charFlash),
`ifdef TEXT_CURSOR_EN
        .cursorAddr(7'd0), .cursorEn(1'b0),
`endif
        .readEn(readEn2), .charAddr(charAddr2), .glyphRow(glyphRow2), .glyphCol(glyphCol2),
        .flashPhase(flashPhase2), .vgaRGB(vgaRGB2));

    // -1 = don't care; rgb: 1 = charRGB, 0 = bgRGB
    typedef struct {
        int tag; int line; int pix;
        int rd; int ca; int gr; int gc; int rgb;
        int rd2; int gr2; int gc2;
    } vec_t;

    vec_t vecs[$];
    int   nChecks = 0;
    int   nFail = 0;
    int   curTag = 0;
    int   prevLine = 0;
    int   expCnt = 0;
    int   expPhase = 0;
    bit   afterReset = 0;
    bit   viol148 = 0, violRst = 0, violTrunc = 0;
    int   smpRgb, smpPhase, smpPhase2;

    task automatic addV(input int tag, input int line, input int pix, input int rd, input int ca,
                        input int gr, input int gc, input int rgb, input int rd2, input int gr2,
                        input int gc2);
        vec_t v;
        v.tag = tag; v.line = line; v.pix = pix; v.rd = rd; v.ca = ca; v.gr = gr; v.gc = gc;
        v.rgb = rgb; v.rd2 = rd2; v.gr2 = gr2; v.gc2 = gc2;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkVec(input vec_t v);
        string at;
        at = $sformatf("L%0d P%0d", v.line, v.pix);
        if (v.rd  >= 0) chk({"readEn ", at}, int'(readEn), v.rd);
        if (v.ca  >= 0) chk({"charAddr ", at}, int'(charAddr), v.ca);
        if (v.gr  >= 0) chk({"glyphRow ", at}, int'(glyphRow), v.gr);
        if (v.gc  >= 0) chk({"glyphCol ", at}, int'(glyphCol), v.gc);
        if (v.rgb >= 0) chk({"vgaRGB ", at}, int'(vgaRGB), v.rgb == 1 ? int'(charRGB) : int'(bgRGB));
        if (v.rd2 >= 0) chk({"x2 readEn ", at}, int'(readEn2), v.rd2);
        if (v.gr2 >= 0) chk({"x2 glyphRow ", at}, int'(glyphRow2), v.gr2);
        if (v.gc2 >= 0) chk({"x2 glyphCol ", at}, int'(glyphCol2), v.gc2);
    endtask

    // One pixel clock: drive, clock, then inspect outputs 1ns after the edge.
    task automatic step(input int ln, input int px);
        lineCnt  = LINE_W'(ln);
        pixelCnt = PIX_W'(px);
        if (ln == 0 && prevLine != 0) begin
            expCnt++;
            if (expCnt == 2) begin
                expCnt = 0;
                expPhase = 1 - expPhase;
            end
        end
        prevLine = ln;
        @(posedge clock);
        #1;
        foreach (vecs[i])
            if (vecs[i].tag == curTag && vecs[i].line == ln && vecs[i].pix == px) checkVec(vecs[i]);
        if (curTag == 0 && ln == 148 && readEn) viol148 = 1;
        if (curTag == 2 && ln == 21 && px < 600 && readEn) violTrunc = 1;
        if (afterReset && (readEn || readEn2)) violRst = 1;
        if (ln == 20 && px == 50) begin
            smpRgb = int'(vgaRGB);
            smpPhase = int'(flashPhase);
            smpPhase2 = int'(flashPhase2);
        end
    endtask

    function automatic bit isFull(input int tag, input int ln);
        case (tag)
            0: return ln inside {20, 21, 22, 36, 147, 148, 275, 276};
            1, 3: return ln == 20;
            2: return ln == 20 || ln == 21;
            4: return ln >= 30 && ln <= 32;
            default: return 1'b0;
        endcase
    endfunction

    task automatic runLines(input int from, input int to, input int tag);
        curTag = tag;
        for (int ln = from; ln <= to; ln++)
            for (int px = 0; px <= (isFull(tag, ln) ? 639 : 1); px++) step(ln, px);
    endtask

    initial begin
        pixelCnt = '0; lineCnt = '0; posHorStart = 10'd40; posVerStart = 9'd20;
        flashEn = 1'b0; bitDisp = 1'b1; charFlash = 1'b1;
        charRGB = 9'o752; bgRGB = 9'o123;

        //   tag line pix  rd  ca  gr  gc rgb rd2 gr2 gc2
        addV(0, 20,  39,  0, -1, -1, -1,  0,  0, -1, -1);
        addV(0, 20,  40,  1,  0,  0,  0,  0,  1,  0,  0);
        addV(0, 20,  41,  1,  0, -1,  1,  0, -1, -1,  0);
        addV(0, 20,  42,  1,  0, -1,  2,  1, -1, -1,  1);
        addV(0, 20,  47,  1,  0, -1,  7, -1, -1, -1, -1);
        addV(0, 20,  48,  1,  1, -1,  0, -1, -1, -1, -1);
        addV(0, 20, 167,  1, 15,  0,  7, -1,  1, -1,  7);
        addV(0, 20, 168,  0, -1, -1, -1,  1,  1, -1, -1);
        addV(0, 20, 169,  0, -1, -1, -1,  1, -1, -1, -1);
        addV(0, 20, 170, -1, -1, -1, -1,  0, -1, -1, -1);
        addV(0, 20, 295, -1, -1, -1, -1, -1,  1, -1,  7);
        addV(0, 20, 296, -1, -1, -1, -1, -1,  0, -1, -1);
        addV(0, 21,  40,  1,  0,  1,  0, -1,  1,  0, -1);
        addV(0, 22,  40,  1,  0,  2, -1, -1,  1,  1, -1);
        addV(0, 36,  40,  1, 16,  0,  0, -1, -1, -1, -1);
        addV(0, 36,  56,  1, 18,  0,  0, -1, -1, -1, -1);
        addV(0, 147, 40,  1, 112, 15, 0, -1, -1, -1, -1);
        addV(0, 147, 167, 1, 127, 15, 7, -1, -1, -1, -1);
        addV(0, 148, 40,  0, -1, -1, -1, -1,  1,  0, -1);
        addV(0, 275, 40,  0, -1, -1, -1, -1,  1, 15, -1);
        addV(0, 276, 40, -1, -1, -1, -1, -1,  0, -1, -1);
        addV(1, 20,  39,  0, -1, -1, -1, -1,  0, -1, -1);
        addV(1, 20,  40,  1,  0,  0,  0, -1,  1,  0,  0);
        addV(2, 20, 599,  0, -1, -1, -1, -1, -1, -1, -1);
        addV(2, 20, 600,  1,  0,  0,  0, -1, -1, -1, -1);
        addV(2, 20, 639,  1,  4,  0,  7, -1,  1, -1, -1);
        addV(2, 21,   0,  0, -1, -1, -1, -1,  0, -1, -1);
        addV(2, 21, 600,  1,  0,  1,  0, -1, -1, -1, -1);

        repeat (3) @(posedge clock);
        #1;
        chk("reset readEn", int'(readEn), 0);
        chk("reset vgaRGB", int'(vgaRGB), 0);
        chk("reset flashPhase", int'(flashPhase), 0);
        chk("reset charAddr", int'(charAddr), 0);
        chk("reset glyphRow", int'(glyphRow), 0);
        chk("reset glyphCol", int'(glyphCol), 0);
        chk("reset x2 readEn", int'(readEn2), 0);
        reset = 1'b1;

        runLines(0, 479, 0);
        chk("no readEn on line 148", int'(viol148), 0);

        // Flash: flashEn on for frames 1-4, off for 5-6.
        flashEn = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            if (f == 5) flashEn = 1'b0;
            runLines(0, 479, 3);
            chk($sformatf("flashPhase frame %0d", f), smpPhase, expPhase);
            chk($sformatf("x2 flashPhase frame %0d", f), smpPhase2, expPhase);
            chk($sformatf("flash vgaRGB frame %0d", f), smpRgb,
                (flashEn && expPhase == 1) ? int'(bgRGB) : int'(charRGB));
        end

        // Asynchronous reset in the middle of an open window with flashPhase=1.
        flashEn = 1'b1;
        runLines(0, 29, 5);
        for (int px = 0; px <= 100; px++) step(30, px);
        chk("window open before reset", int'(readEn), 1);
        chk("flashPhase before reset", int'(flashPhase), expPhase);
        chk("model phase before reset", expPhase, 1);
        #2 reset = 1'b0;
        #1;
        chk("async reset readEn", int'(readEn), 0);
        chk("async reset vgaRGB", int'(vgaRGB), 0);
        chk("async reset flashPhase", int'(flashPhase), 0);
        chk("async reset charAddr", int'(charAddr), 0);
        chk("async reset x2 readEn", int'(readEn2), 0);
        step(30, 101);
        step(30, 102);
        reset = 1'b1;
        expCnt = 0;
        expPhase = 0;
        prevLine = 0;
        afterReset = 1;
        curTag = 4;
        for (int px = 103; px <= 639; px++) step(30, px);
        runLines(31, 479, 4);
        afterReset = 0;
        chk("no readEn after reset until next match", int'(violRst), 0);
        runLines(0, 479, 1);

        // Window truncated by the end of the line.
        posHorStart = 10'd600;
        runLines(0, 479, 2);
        chk("no readEn on line 21 before pixel 600", int'(violTrunc), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
